decode_hazard_pipe: RTL

//  Parametrised decode-stage back end: NREGS x DATA_W register file, load-use/WB

---
 rtl/decode_hazard_pipe_if.sv | 53 +++++
 rtl/decode_hazard_pipe.sv | 120 ++++++++++++
 2 files changed

// File: rtl/decode_hazard_pipe_if.sv
// Decode-to-execute bundle: decoded fields in, handshake, writeback port,
// registered ID/EX bundle out and the stall indication.
interface decode_hazard_pipe_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CTRL_W = 32
);
  logic              id_valid;
  logic              id_ready;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_use;
  logic              id_rt_use;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrt;
  logic              id_memread;
  logic [CTRL_W-1:0] id_ctrl;
  logic [DATA_W-1:0] id_imm;
  logic              id_err;
  logic              flush;
  logic              ex_ready;
  logic              wb_en;
  logic [REG_AW-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrt;
  logic              ex_memread;
  logic              ex_err;
  logic              stall;

  // Upstream decode / writeback / EX side.
  modport master (
    output id_valid, id_rs, id_rt, id_rs_use, id_rt_use, id_rd, id_regwrt,
           id_memread, id_ctrl, id_imm, id_err, flush, ex_ready,
           wb_en, wb_reg, wb_data,
    input  id_ready, ex_valid, ex_ctrl, ex_imm, ex_a, ex_b, ex_rd,
           ex_regwrt, ex_memread, ex_err, stall
  );

  // Decode back end.
  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_use, id_rt_use, id_rd, id_regwrt,
           id_memread, id_ctrl, id_imm, id_err, flush, ex_ready,
           wb_en, wb_reg, wb_data,
    output id_ready, ex_valid, ex_ctrl, ex_imm, ex_a, ex_b, ex_rd,
           ex_regwrt, ex_memread, ex_err, stall
  );
endinterface

// File: rtl/decode_hazard_pipe.sv
// Decode-stage back end: NREGS x DATA_W register file, load-use / writeback
// hazard detection with stall, and the ID/EX pipeline register with
// valid/ready handshake and flush.
// Optional feature macro: DECODE_BYPASS_EN (write-before-read regfile bypass;
// when undefined a same-cycle writeback to a used source register stalls).
module decode_hazard_pipe #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CTRL_W = 32
) (
  input logic                clk,
  input logic                rst,
  decode_hazard_pipe_if.slave bus
);
  localparam int NREGS = 2 ** REG_AW;

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_AW-1:0] rd;
    logic              regwrt;
    logic              memread;
    logic              err;
  } ex_t;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  ex_t               ex_q;
  ex_t               ex_d;

  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              load_use;
  logic              wb_hazard;
  logic              hazard;
  logic              advance;
  logic              id_ready;

  // Combinational register reads, optionally bypassing the writeback port.
  always_comb begin
    rd_a = regs_q[bus.id_rs];
    rd_b = regs_q[bus.id_rt];
`ifdef DECODE_BYPASS_EN
    if (bus.wb_en && (bus.wb_reg == bus.id_rs)) rd_a = bus.wb_data;
    if (bus.wb_en && (bus.wb_reg == bus.id_rt)) rd_b = bus.wb_data;
`endif
  end

  // Hazard detection and ID/EX handshake.
  always_comb begin
    load_use = ex_q.valid && ex_q.memread && ex_q.regwrt &&
               ((bus.id_rs_use && (bus.id_rs == ex_q.rd)) ||
                (bus.id_rt_use && (bus.id_rt == ex_q.rd)));
`ifdef DECODE_BYPASS_EN
    wb_hazard = 1'b0;
`else
    wb_hazard = bus.wb_en &&
                ((bus.id_rs_use && (bus.id_rs == bus.wb_reg)) ||
                 (bus.id_rt_use && (bus.id_rt == bus.wb_reg)));
`endif
    hazard   = load_use || wb_hazard;
    advance  = bus.ex_ready || !ex_q.valid;
    id_ready = advance && !hazard && !bus.flush;
  end

  // Register file next state: single write port.
  always_comb begin
    regs_d = regs_q;
    if (bus.wb_en) regs_d[bus.wb_reg] = bus.wb_data;
  end

  // ID/EX next state: flush > hold > bubble > load.
  // Bubble and flush clear only valid/control/flags; operand fields are kept.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush || (advance && (!bus.id_valid || hazard))) begin
      ex_d.valid   = 1'b0;
      ex_d.ctrl    = '0;
      ex_d.regwrt  = 1'b0;
      ex_d.memread = 1'b0;
      ex_d.err     = 1'b0;
    end else if (advance) begin
      ex_d.valid   = 1'b1;
      ex_d.ctrl    = bus.id_ctrl;
      ex_d.imm     = bus.id_imm;
      ex_d.a       = rd_a;
      ex_d.b       = rd_b;
      ex_d.rd      = bus.id_rd;
      ex_d.regwrt  = bus.id_regwrt;
      ex_d.memread = bus.id_memread;
      ex_d.err     = bus.id_err;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regs_q <= '{default: '0};
      ex_q   <= '0;
    end else begin
      regs_q <= regs_d;
      ex_q   <= ex_d;
    end
  end

  assign bus.id_ready   = id_ready;
  assign bus.stall      = bus.id_valid && !id_ready;
  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_ctrl    = ex_q.ctrl;
  assign bus.ex_imm     = ex_q.imm;
  assign bus.ex_a       = ex_q.a;
  assign bus.ex_b       = ex_q.b;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_regwrt  = ex_q.regwrt;
  assign bus.ex_memread = ex_q.memread;
  assign bus.ex_err     = ex_q.err;
endmodule
